// File: rtl/decode_stage_pkg.sv
// Shared definitions for the decode stage: datapath sizes, opcode
// constants, instruction field positions and a sign-extension helper.
package decode_stage_pkg;

  localparam int DSIZE = 16;
  localparam int NREG  = 16;

  localparam logic [3:0] ADD = 4'h0;
  localparam logic [3:0] SUB = 4'h1;
  localparam logic [3:0] AND = 4'h2;
  localparam logic [3:0] OR  = 4'h3;
  localparam logic [3:0] SLL = 4'h4;
  localparam logic [3:0] SRL = 4'h5;
  localparam logic [3:0] SRA = 4'h6;
  localparam logic [3:0] RL  = 4'h7;
  localparam logic [3:0] LLB = 4'hB;

  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int RD_HI = 11;
  localparam int RD_LO = 8;
  localparam int RS_HI = 7;
  localparam int RS_LO = 4;
  localparam int RT_HI = 3;
  localparam int RT_LO = 0;

  function automatic logic [DSIZE-1:0] sext8(input logic [7:0] v);
    return {{(DSIZE-8){v[7]}}, v};
  endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// NREG x DSIZE register file with two combinational read ports and one
// synchronous write port. R0 is never written and always reads zero.
// Ports:
//   clk, rst_n        clock, asynchronous active-low clear of all registers
//   ra_addr/ra_data   read port A
//   rb_addr/rb_data   read port B
//   we, wa, wd        write strobe, address, data
module reg_file
  import decode_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       ra_addr,
  output logic [DSIZE-1:0] ra_data,
  input  logic [3:0]       rb_addr,
  output logic [DSIZE-1:0] rb_data,
  input  logic             we,
  input  logic [3:0]       wa,
  input  logic [DSIZE-1:0] wd
);

  logic [DSIZE-1:0] mem [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && (wa != 4'd0)) begin
      mem[wa] <= wd;
    end
  end

  assign ra_data = (ra_addr == 4'd0) ? '0 : mem[ra_addr];
  assign rb_data = (rb_addr == 4'd0) ? '0 : mem[rb_addr];

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage feeding the 16-bit ALU. Accepts one instruction
// per cycle over valid/ready, stalls on read-after-write hazards using a
// per-register pending scoreboard, bypasses same-cycle writeback data and
// presents registered operands one cycle after acceptance.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid, in_instr, in_ready  fetch handshake (in_ready combinational)
//   flush                         drop the instruction handshaking this cycle
//   wb_en, wb_addr, wb_data       writeback into the register file
//   out_valid, out_A, out_B,
//   out_op, out_imm, out_rd       registered ALU issue
//   illegal                       one-cycle pulse for a dropped bad opcode
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [15:0]      in_instr,
  output logic             in_ready,
  input  logic             flush,
  input  logic             wb_en,
  input  logic [3:0]       wb_addr,
  input  logic [DSIZE-1:0] wb_data,
  output logic             out_valid,
  output logic [DSIZE-1:0] out_A,
  output logic [DSIZE-1:0] out_B,
  output logic [2:0]       out_op,
  output logic [3:0]       out_imm,
  output logic [3:0]       out_rd,
  output logic             illegal
);

  logic [3:0] op, rd, rs, rt;
  assign op = in_instr[OP_HI:OP_LO];
  assign rd = in_instr[RD_HI:RD_LO];
  assign rs = in_instr[RS_HI:RS_LO];
  assign rt = in_instr[RT_HI:RT_LO];

  logic is_rr, is_sh, is_llb, legal;
  always_comb begin
    is_rr  = 1'b0;
    is_sh  = 1'b0;
    is_llb = 1'b0;
    unique case (op)
      ADD, SUB, AND, OR:  is_rr  = 1'b1;
      SLL, SRL, SRA, RL:  is_sh  = 1'b1;
      LLB:                is_llb = 1'b1;
      default:            ;
    endcase
    legal = is_rr | is_sh | is_llb;
  end

  // Writeback clear is applied before the hazard check so a consumer can
  // issue in the same cycle its producer's result arrives.
  logic             wb_hit;
  logic [NREG-1:0]  pending, clr_vec, set_vec, pending_eff;
  logic             rs_busy, rt_busy, accept, issue;

  assign wb_hit      = wb_en & (wb_addr != 4'd0);
  assign clr_vec     = wb_hit ? (NREG'(1) << wb_addr) : '0;
  assign pending_eff = pending & ~clr_vec;

  assign rs_busy  = (is_rr | is_sh) & (rs != 4'd0) & pending_eff[rs];
  assign rt_busy  = is_rr & (rt != 4'd0) & pending_eff[rt];
  assign in_ready = rst_n & ~(rs_busy | rt_busy);

  assign accept  = in_valid & in_ready & ~flush;
  assign issue   = accept & legal;
  assign set_vec = (issue && (rd != 4'd0)) ? (NREG'(1) << rd) : '0;

  logic [DSIZE-1:0] rf_a, rf_b, rs_val, rt_val;

  reg_file u_reg_file (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (rs),
    .ra_data (rf_a),
    .rb_addr (rt),
    .rb_data (rf_b),
    .we      (wb_en),
    .wa      (wb_addr),
    .wd      (wb_data)
  );

  assign rs_val = (wb_hit && (wb_addr == rs)) ? wb_data : rf_a;
  assign rt_val = (wb_hit && (wb_addr == rt)) ? wb_data : rf_b;

  logic [DSIZE-1:0] a_nxt, b_nxt;
  logic [2:0]       op_nxt;
  logic [3:0]       imm_nxt;
  always_comb begin
    a_nxt   = '0;
    b_nxt   = '0;
    op_nxt  = op[2:0];
    imm_nxt = '0;
    if (is_rr) begin
      a_nxt = rs_val;
      b_nxt = rt_val;
    end else if (is_sh) begin
      a_nxt   = rs_val;
      imm_nxt = rt;
    end else if (is_llb) begin
      b_nxt  = sext8({rs, rt});
      op_nxt = ADD[2:0];
    end
  end

  // Set wins over clear for the same register: the new writer is pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      out_A     <= '0;
      out_B     <= '0;
      out_op    <= '0;
      out_imm   <= '0;
      out_rd    <= '0;
    end else begin
      pending   <= pending_eff | set_vec;
      out_valid <= issue;
      illegal   <= accept & ~legal;
      if (issue) begin
        out_A   <= a_nxt;
        out_B   <= b_nxt;
        out_op  <= op_nxt;
        out_imm <= imm_nxt;
        out_rd  <= rd;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_instr;
  logic        in_ready;
  logic        flush;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        out_valid;
  logic [15:0] out_A, out_B;
  logic [2:0]  out_op;
  logic [3:0]  out_imm, out_rd;
  logic        illegal;

  decode_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .flush     (flush),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_A     (out_A),
    .out_B     (out_B),
    .out_op    (out_op),
    .out_imm   (out_imm),
    .out_rd    (out_rd),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model: architectural registers, pending flags, expected issue
  int          mregs [16];
  bit          mpend [16];
  bit          e_valid, e_ill;
  logic [15:0] e_A, e_B;
  logic [2:0]  e_op;
  logic [3:0]  e_imm, e_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mregs[i] = 0;
      mpend[i] = 1'b0;
    end
    e_valid = 1'b0;
    e_ill   = 1'b0;
  endtask

  function automatic int rdv(input int r, input int clr, input int wd);
    if (r == 0) return 0;
    if (r == clr) return wd;
    return mregs[r];
  endfunction

  // Apply one cycle of inputs, check in_ready before the edge and the
  // registered issue after it.
  task automatic step(input bit v, input logic [15:0] ins, input bit fl,
                      input bit we, input logic [3:0] wa, input logic [15:0] wd);
    int op, rd, rs, rt, clr, imm8;
    bit legal, busy;
    in_valid = v; in_instr = ins; flush = fl;
    wb_en = we; wb_addr = wa; wb_data = wd;
    op = int'(ins[15:12]); rd = int'(ins[11:8]);
    rs = int'(ins[7:4]);   rt = int'(ins[3:0]);
    clr   = (we && wa != 4'd0) ? int'(wa) : -1;
    legal = (op <= 7) || (op == 11);
    busy  = 1'b0;
    if (op <= 7 && rs != 0 && mpend[rs] && rs != clr) busy = 1'b1;
    if (op <= 3 && rt != 0 && mpend[rt] && rt != clr) busy = 1'b1;
    #2;
    chk("in_ready", in_ready, !busy);
    e_valid = v && !busy && !fl && legal;
    e_ill   = v && !busy && !fl && !legal;
    if (e_valid) begin
      e_rd = rd[3:0];
      if (op <= 3) begin
        e_A = 16'(rdv(rs, clr, int'(wd))); e_B = 16'(rdv(rt, clr, int'(wd)));
        e_op = op[2:0]; e_imm = 4'd0;
      end else if (op <= 7) begin
        e_A = 16'(rdv(rs, clr, int'(wd))); e_B = 16'd0;
        e_op = op[2:0]; e_imm = rt[3:0];
      end else begin
        imm8 = rs * 16 + rt;
        e_A = 16'd0; e_B = 16'((imm8 >= 128) ? imm8 + 'hFF00 : imm8);
        e_op = 3'd0; e_imm = 4'd0;
      end
    end
    if (clr >= 0) begin
      mregs[clr] = int'(wd);
      mpend[clr] = 1'b0;
    end
    if (e_valid && rd != 0) mpend[rd] = 1'b1;
    @(posedge clk); #1;
    chk("out_valid", out_valid, e_valid);
    chk("illegal", illegal, e_ill);
    if (e_valid) begin
      chk("out_A", out_A, e_A);
      chk("out_B", out_B, e_B);
      chk("out_op", out_op, e_op);
      chk("out_imm", out_imm, e_imm);
      chk("out_rd", out_rd, e_rd);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, in_ready, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_A"}, out_A, 0);
    chk({tag, "_B"}, out_B, 0);
    chk({tag, "_op"}, out_op, 0);
    chk({tag, "_imm"}, out_imm, 0);
    chk({tag, "_rd"}, out_rd, 0);
    chk({tag, "_ill"}, illegal, 0);
  endtask

  initial begin
    logic [15:0] ins;
    int r;
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    model_reset();
    #3;
    chk_all_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // load r1 then ALU op
    step(1, 16'hB105, 0, 0, 0, 0);
    chk("llb_B", out_B, 16'h0005);
    step(0, 16'h0000, 0, 1, 1, 16'h0005);
    step(1, 16'h0211, 0, 0, 0, 0);
    chk("add_A", out_A, 16'h0005);

    // RAW stall released by bypass
    step(1, 16'h0311, 0, 0, 0, 0);
    step(1, 16'h1431, 0, 0, 0, 0);
    step(1, 16'h1431, 0, 0, 0, 0);
    step(1, 16'h1431, 0, 1, 3, 16'h000A);
    chk("raw_bypass_A", out_A, 16'h000A);

    // shift: rt field is an immediate, not a source
    step(1, 16'h0311, 0, 0, 0, 0);
    step(1, 16'h6533, 0, 0, 0, 0);
    step(1, 16'h6533, 0, 1, 3, 16'h0007);
    chk("sra_imm", out_imm, 4'd3);
    step(1, 16'h0F11, 0, 0, 0, 0);
    step(1, 16'h461F, 0, 0, 0, 0);
    chk("sll_imm", out_imm, 4'd15);

    // illegal opcode and flush
    step(1, 16'h9123, 0, 0, 0, 0);
    step(1, 16'h0711, 1, 0, 0, 0);
    step(1, 16'h1977, 0, 0, 0, 0);

    // set/clear collision on r2
    step(1, 16'h0211, 0, 1, 2, 16'h1234);
    step(1, 16'h3822, 0, 0, 0, 0);
    step(1, 16'h3822, 0, 0, 0, 0);
    step(1, 16'h3822, 0, 1, 2, 16'h00F0);
    chk("collide_A", out_A, 16'h00F0);

    // asynchronous reset while stalled on r8
    in_valid = 1'b1; in_instr = 16'h0A88; flush = 1'b0; wb_en = 1'b0;
    #2;
    chk("stall_before_rst", in_ready, 0);
    #1 rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1, 16'h0B10, 0, 0, 0, 0);
    chk("r1_after_rst", out_A, 16'h0000);
    step(1, 16'h0A88, 0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      ins = 16'($urandom);
      r = int'($urandom_range(0, 9));
      if (r < 4)      ins[15:12] = 4'($urandom_range(0, 3));
      else if (r < 7) ins[15:12] = 4'($urandom_range(4, 7));
      else if (r < 9) ins[15:12] = 4'hB;
      step($urandom_range(0, 9) < 8, ins, $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) < 4, 4'($urandom), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
